// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store memory stage with req/ack data-memory handshake
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  tcount;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        st_q;

    logic        illegal;
    logic        misaligned;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext_data;

    assign req_ready = (state == IDLE);

    // Classify the incoming request and build store lanes from the live inputs.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        lane_wdata = '0;
        lane_wstrb = '0;
        if (is_store) begin
            illegal = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    lane_wdata = {4{store_data[7:0]}};
                    lane_wstrb = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    lane_wdata = {2{store_data[15:0]}};
                    lane_wstrb = 4'b0011 << addr[1:0];
                end
                default: begin
                    lane_wdata = store_data;
                    lane_wstrb = 4'b1111;
                end
            endcase
        end
    end

    // Pick the addressed byte/half out of the read word and extend it.
    always_comb begin
        byte_v   = mem_rdata[{off_q, 3'b000} +: 8];
        half_v   = mem_rdata[{off_q[1], 4'b0000} +: 16];
        ext_data = '0;
        case (f3_q)
            3'b000:  ext_data = {{24{byte_v[7]}}, byte_v};
            3'b001:  ext_data = {{16{half_v[15]}}, half_v};
            3'b010:  ext_data = mem_rdata;
            3'b100:  ext_data = {24'h0, byte_v};
            3'b101:  ext_data = {16'h0, half_v};
            default: ext_data = '0;
        endcase
    end

    // Control FSM: accept, drive the memory request, then emit one response pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            tcount     <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            st_q       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            resp_valid <= 1'b0;
            load_data  <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q   <= funct3;
                        off_q  <= addr[1:0];
                        st_q   <= is_store;
                        tcount <= '0;
                        if (illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            err        <= 1'b1;
                            err_code   <= 2'b10;
                            load_data  <= '0;
                        end else if (misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            err        <= 1'b1;
                            err_code   <= 2'b01;
                            load_data  <= '0;
                        end else begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= lane_wdata;
                            mem_wstrb <= lane_wstrb;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        err        <= 1'b0;
                        err_code   <= 2'b00;
                        load_data  <= st_q ? 32'h0 : ext_data;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_wstrb  <= '0;
                    end else if (tcount == TMO_LAST) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        err        <= 1'b1;
                        err_code   <= 2'b11;
                        load_data  <= '0;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_wstrb  <= '0;
                    end else begin
                        tcount <= tcount + 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
